caesar_link_ctrl: RTL

Runtime-configurable controller between the UART receiver and transmitter of the Caesar echo path. It parses in-band ESC commands to set the shift key and the encrypt/decrypt mode, and ciphers each data byte at enqueue time. It buffers ciphertext in a byte FIFO and sequences the transmitter one byte at a time, so back-to-back received bytes are never lost while the TX is busy.

---
 rtl/caesar_pkg.sv | 54 +++++
 rtl/caesar_link_ctrl_if.sv | 33 +++
 rtl/caesar_link_ctrl_fifo.sv | 69 ++++++
 rtl/caesar_link_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/caesar_pkg.sv
// Shared constants, FSM state types and the Caesar cipher arithmetic
// for the UART echo path.
package caesar_pkg;

    localparam logic [7:0]  ESC     = 8'h1B;
    localparam logic [7:0]  CMD_ENC = 8'h45;
    localparam logic [7:0]  CMD_DEC = 8'h44;
    localparam logic [7:0]  KEY_MAX = 8'h19;
    localparam int unsigned ALPHA   = 26;

    typedef enum logic {
        P_DATA,
        P_CMD
    } parse_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ACK,
        S_WAIT
    } seq_state_e;

    // Rotate letters by s (0..25); everything else passes through.
    function automatic logic [7:0] caesar_apply(byte c, logic [4:0] s);
        logic [7:0] u;
        logic [7:0] base;
        logic [5:0] sum;
        logic       letter;
        u      = 8'(c);
        base   = 8'h41;
        letter = 1'b1;
        if (u >= 8'h41 && u <= 8'h5A) begin
            base = 8'h41;
        end else if (u >= 8'h61 && u <= 8'h7A) begin
            base = 8'h61;
        end else begin
            letter = 1'b0;
        end
        sum = 6'(u - base) + 6'(s);
        if (sum >= 6'(ALPHA)) begin
            sum = sum - 6'(ALPHA);
        end
        return letter ? (base + 8'(sum)) : u;
    endfunction

    // Decrypting by k is encrypting by (26 - k) mod 26.
    function automatic logic [4:0] eff_shift(logic [4:0] key, logic dec);
        if (dec && (key != 5'd0)) begin
            return 5'(ALPHA) - key;
        end
        return key;
    endfunction

endpackage

// File: rtl/caesar_link_ctrl_if.sv
// RX/TX handshake and status bundle between the link controller and its
// UART neighbours.
interface caesar_link_ctrl_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             tx_busy;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             overflow;
    logic [7:0]       drop_cnt;
    logic [LVL_W-1:0] fifo_level;
    logic [4:0]       shift_o;
    logic             decrypt_o;

    // Controller side
    modport master (
        input  rx_valid, rx_data, tx_busy,
        output tx_start, tx_data, overflow, drop_cnt, fifo_level,
               shift_o, decrypt_o
    );

    // UART / observer side
    modport slave (
        output rx_valid, rx_data, tx_busy,
        input  tx_start, tx_data, overflow, drop_cnt, fifo_level,
               shift_o, decrypt_o
    );

endinterface

// File: rtl/caesar_link_ctrl_fifo.sv
// Synchronous byte FIFO with show-ahead read; pushes into a full FIFO and
// pops from an empty one are ignored.
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push;
    logic          do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q];
    assign level   = level_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/caesar_link_ctrl.sv
// Caesar echo-path link controller: in-band ESC command parser, enqueue-time
// cipher, byte FIFO and one-byte-at-a-time UART TX sequencer.
module caesar_link_ctrl
    import caesar_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned INIT_SHIFT = 3
) (
    input  logic               clk50,
    input  logic               reset_n,
    caesar_link_ctrl_if.master bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("caesar_link_ctrl: DEPTH must be a power of two >= 2");
    end
    if (INIT_SHIFT > 25) begin : g_bad_shift
        $error("caesar_link_ctrl: INIT_SHIFT must be 0..25");
    end

    parse_state_e     parse_q, parse_d;
    logic [4:0]       shift_q, shift_d;
    logic             decrypt_q, decrypt_d;
    logic             push_c;
    logic [7:0]       push_data_c;

    seq_state_e       seq_q, seq_d;
    logic             pop_c;
    logic             tx_start_q;
    logic [7:0]       tx_data_q, tx_data_d;

    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic [7:0]       fifo_dout;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_full;
    logic             fifo_empty;

    // Command parser; data bytes are ciphered with the key in force right now.
    always_comb begin
        parse_d     = parse_q;
        shift_d     = shift_q;
        decrypt_d   = decrypt_q;
        push_c      = 1'b0;
        push_data_c = caesar_apply(byte'(bus.rx_data), eff_shift(shift_q, decrypt_q));
        if (bus.rx_valid) begin
            case (parse_q)
                P_DATA: begin
                    if (bus.rx_data == ESC) begin
                        parse_d = P_CMD;
                    end else begin
                        push_c = 1'b1;
                    end
                end
                P_CMD: begin
                    parse_d = P_DATA;
                    if (bus.rx_data <= KEY_MAX) begin
                        shift_d = 5'(bus.rx_data);
                    end else if (bus.rx_data == CMD_ENC) begin
                        decrypt_d = 1'b0;
                    end else if (bus.rx_data == CMD_DEC) begin
                        decrypt_d = 1'b1;
                    end else if (bus.rx_data == ESC) begin
                        push_c      = 1'b1;
                        push_data_c = ESC;
                    end
                end
            endcase
        end
    end

    // Drop accounting: a push into a full FIFO is lost even if a pop coincides.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (push_c && fifo_full) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    // TX sequencer: ACK absorbs the transmitter's one-cycle busy latency.
    always_comb begin
        seq_d     = seq_q;
        pop_c     = 1'b0;
        tx_data_d = tx_data_q;
        case (seq_q)
            S_IDLE: begin
                if (!fifo_empty && !bus.tx_busy) begin
                    pop_c     = 1'b1;
                    tx_data_d = fifo_dout;
                    seq_d     = S_START;
                end
            end
            S_START: seq_d = S_ACK;
            S_ACK:   seq_d = S_WAIT;
            S_WAIT: begin
                if (!bus.tx_busy) begin
                    seq_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            parse_q    <= P_DATA;
            shift_q    <= 5'(INIT_SHIFT);
            decrypt_q  <= 1'b0;
            seq_q      <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'h00;
        end else begin
            parse_q    <= parse_d;
            shift_q    <= shift_d;
            decrypt_q  <= decrypt_d;
            seq_q      <= seq_d;
            tx_start_q <= (seq_d == S_START);
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk50),
        .rst_n (reset_n),
        .push  (push_c),
        .pop   (pop_c),
        .din   (push_data_c),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.tx_start   = tx_start_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_cnt_q;
    assign bus.fifo_level = fifo_level;
    assign bus.shift_o    = shift_q;
    assign bus.decrypt_o  = decrypt_q;

endmodule
